// File: rtl/shift_pkg.sv
// Shared definitions for the lane-granular shifters (left pipe and right combinational).
package shift_pkg;

  localparam int unsigned LANE_W    = 5;
  localparam int unsigned LANES     = 10;
  localparam int unsigned DATA_W    = LANE_W * LANES;
  localparam int unsigned SHIFT_W   = 3;
  localparam int unsigned MAX_SHIFT = 4;

  typedef logic [LANES-1:0][LANE_W-1:0] lane_arr_t;

  function automatic logic shift_in_range(input logic [SHIFT_W-1:0] s);
    return s <= SHIFT_W'(MAX_SHIFT);
  endfunction

endpackage

// File: rtl/shift_left_pipe_if.sv
// Upstream and downstream handshake signals of the pipelined left shifter.
interface shift_left_pipe_if;

  logic                                   in_valid;
  logic                                   in_ready;
  logic [shift_pkg::DATA_W-1:0]           in;
  logic [shift_pkg::SHIFT_W-1:0]          shift;
  logic [shift_pkg::LANE_W-1:0]           fill;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [shift_pkg::DATA_W-1:0]           out;
  logic                                   out_range_ok;

  modport slave (
    input  in_valid, in, shift, fill, out_ready,
    output in_ready, out_valid, out, out_range_ok
  );

  modport master (
    output in_valid, in, shift, fill, out_ready,
    input  in_ready, out_valid, out, out_range_ok
  );

endinterface

// File: rtl/shift_left_stage.sv
// Combinational left shift by a fixed lane count when sel is set; vacated low lanes take fill.
module shift_left_stage
  import shift_pkg::*;
#(
  parameter int unsigned SHIFT_LANES = 1
) (
  input  lane_arr_t         d,
  input  logic              sel,
  input  logic [LANE_W-1:0] fill,
  output lane_arr_t         q
);

  assign q = sel ? lane_arr_t'({d[LANES-1-SHIFT_LANES:0], {SHIFT_LANES{fill}}}) : d;

endmodule

// File: rtl/shift_left_pipe.sv
// Two-stage lane left shifter: stage 1 shifts by 1/2 lanes, stage 2 by 4 lanes plus range forcing.
module shift_left_pipe
  import shift_pkg::*;
(
  input logic              clk,
  input logic              rst,
  shift_left_pipe_if.slave bus
);

  lane_arr_t         in_lanes;
  lane_arr_t         st1_q;
  lane_arr_t         st2_q;
  lane_arr_t         st4_q;

  logic              s1_valid;
  lane_arr_t         s1_data;
  logic [LANE_W-1:0] s1_fill;
  logic              s1_sh2;
  logic              s1_rok;

  logic              s2_valid;
  lane_arr_t         s2_data;
  logic              s2_rok;

  logic              s1_adv;
  logic              s2_adv;

  assign in_lanes = lane_arr_t'(bus.in);

  shift_left_stage #(.SHIFT_LANES(1)) u_stage1 (
    .d    (in_lanes),
    .sel  (bus.shift[0]),
    .fill (bus.fill),
    .q    (st1_q)
  );

  shift_left_stage #(.SHIFT_LANES(2)) u_stage2 (
    .d    (st1_q),
    .sel  (bus.shift[1]),
    .fill (bus.fill),
    .q    (st2_q)
  );

  shift_left_stage #(.SHIFT_LANES(4)) u_stage4 (
    .d    (s1_data),
    .sel  (s1_sh2),
    .fill (s1_fill),
    .q    (st4_q)
  );

  // Each stage may load whenever it is empty or its contents leave this cycle.
  assign s2_adv   = !s2_valid || bus.out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_fill  <= '0;
      s1_sh2   <= 1'b0;
      s1_rok   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data <= st2_q;
        s1_fill <= bus.fill;
        s1_sh2  <= bus.shift[2];
        s1_rok  <= shift_in_range(bus.shift);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_rok   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= s1_rok ? st4_q : lane_arr_t'({LANES{s1_fill}});
        s2_rok  <= s1_rok;
      end
    end
  end

  assign bus.out          = s2_data;
  assign bus.out_valid    = s2_valid;
  assign bus.out_range_ok = s2_rok;

endmodule

// File: tb/tb_shift_left_pipe.sv
// Self-checking bench for shift_left_pipe: directed cases plus randomized streaming vs a lane model.
module tb_shift_left_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_left_pipe_if b();

  shift_left_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned last_in_cyc = 0;
  int unsigned last_out_cyc = 0;
  logic        in_fire = 1'b0;
  logic        out_fire = 1'b0;
  logic        stall_prev = 1'b0;
  logic [50:0] held = '0;
  logic [50:0] last_out = '0;
  logic [50:0] sbq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {data, range_ok}; out lane k = in lane k-s, low s lanes = fill, all-fill if s>4.
  function automatic logic [50:0] model(input logic [49:0] d, input logic [2:0] s, input logic [4:0] f);
    logic [49:0] r;
    if (s > 3'd4) begin
      for (int k = 0; k < 10; k++) r[5*k +: 5] = f;
      return {r, 1'b0};
    end
    r = d << (5 * int'(s));
    for (int k = 0; k < 10; k++) if (k < int'(s)) r[5*k +: 5] = f;
    return {r, 1'b1};
  endfunction

  task automatic step();
    logic [50:0] e;
    @(negedge clk);
    cyc++;
    in_fire  = 1'b0;
    out_fire = 1'b0;
    if (stall_prev)
      check("stall_hold", {b.out_valid, b.out, b.out_range_ok}, {1'b1, held});
    if (b.out_valid && b.out_ready) begin
      check("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("sb_data", b.out, e[50:1]);
        check("sb_range_ok", b.out_range_ok, e[0]);
      end
      last_out     = {b.out, b.out_range_ok};
      last_out_cyc = cyc;
      out_fire     = 1'b1;
    end
    stall_prev = b.out_valid && !b.out_ready;
    held       = {b.out, b.out_range_ok};
    if (b.in_valid && b.in_ready) begin
      sbq.push_back(model(b.in, b.shift, b.fill));
      last_in_cyc = cyc;
      in_fire     = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [49:0] d, input logic [2:0] s, input logic [4:0] f);
    logic done;
    done       = 1'b0;
    b.in       = d;
    b.shift    = s;
    b.fill     = f;
    b.in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = in_fire;
    end
    check("push_accept", done, 1'b1);
    b.in_valid = 1'b0;
  endtask

  initial begin
    logic [49:0] d1, d2, d3, rd;
    logic [50:0] e1;
    int unsigned beats, outs, budget;

    b.in_valid  = 1'b0;
    b.in        = '0;
    b.shift     = '0;
    b.fill      = '0;
    b.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", b.out_valid, 1'b0);
    check("rst_out", b.out, 50'd0);
    check("rst_range_ok", b.out_range_ok, 1'b0);
    check("rst_in_ready", b.in_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic shift with latency and single-cycle pulse
    b.out_ready = 1'b1;
    push_beat(50'h1F, 3'd3, 5'h0A);
    step();
    step();
    check("basic_latency", 64'(last_out_cyc - last_in_cyc), 64'd2);
    check("basic_out", last_out, {50'hFA94A, 1'b1});
    check("basic_pulse", b.out_valid, 1'b0);

    push_beat(50'h3FFFFFFFFFFFF, 3'd4, 5'h00);
    step();
    step();
    check("max_shift", last_out, {50'h3FFFFFFF00000, 1'b1});

    push_beat(50'h0123456789ABC, 3'd6, 5'h1F);
    step();
    step();
    check("out_of_range", last_out, {50'h3FFFFFFFFFFFF, 1'b0});

    push_beat(50'h2AAAA5555F0F0, 3'd0, 5'h11);
    step();
    step();
    check("shift_zero", last_out, {50'h2AAAA5555F0F0, 1'b1});

    // Backpressure: two beats buffer, third is refused
    d1 = 50'h1234567890ABC;
    d2 = 50'h0FEDCBA987654;
    d3 = 50'h3C3C3C3C3C3C3;
    e1 = model(d1, 3'd2, 5'h03);
    b.out_ready = 1'b0;
    push_beat(d1, 3'd2, 5'h03);
    push_beat(d2, 3'd1, 5'h15);
    b.in = d3; b.shift = 3'd5; b.fill = 5'h07; b.in_valid = 1'b1;
    step();
    check("bp_refuse", in_fire, 1'b0);
    step();
    check("bp_in_ready", b.in_ready, 1'b0);
    check("bp_hold_beat1", {b.out, b.out_range_ok}, e1);
    b.out_ready = 1'b1;
    step();
    check("bp_accept3", in_fire, 1'b1);
    check("bp_out1", out_fire, 1'b1);
    b.in_valid = 1'b0;
    step();
    check("bp_out2", out_fire, 1'b1);
    step();
    check("bp_out3", out_fire, 1'b1);
    check("bp_drained", 64'(sbq.size()), 64'd0);

    // Reset with two beats in flight
    b.out_ready = 1'b0;
    push_beat(50'h155555, 3'd1, 5'h01);
    push_beat(50'h0AAAAA, 3'd2, 5'h02);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", b.out_valid, 1'b0);
    check("midrst_in_ready", b.in_ready, 1'b1);
    sbq.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    b.out_ready = 1'b1;
    push_beat(50'h00000000003E1, 3'd1, 5'h1B);
    step();
    step();
    check("postrst_latency", 64'(last_out_cyc - last_in_cyc), 64'd2);
    check("postrst_out", last_out, {50'h0000000007C3B, 1'b1});

    // Randomized streaming
    beats  = 0;
    outs   = 0;
    budget = 0;
    b.in_valid = 1'b0;
    while (beats < 10000 && budget < 60000) begin
      if (!b.in_valid || in_fire) begin
        rd = {$urandom, $urandom};
        b.in       = rd;
        b.shift    = 3'($urandom);
        b.fill     = 5'($urandom);
        b.in_valid = ($urandom % 4) != 0;
      end
      b.out_ready = ($urandom % 4) != 0;
      step();
      budget++;
      if (in_fire) beats++;
      if (out_fire) outs++;
    end
    check("stream_budget", 64'(beats), 64'd10000);
    b.in_valid  = 1'b0;
    b.out_ready = 1'b1;
    for (int i = 0; i < 10 && sbq.size() != 0; i++) begin
      step();
      if (out_fire) outs++;
    end
    check("stream_drained", 64'(sbq.size()), 64'd0);
    check("stream_count", 64'(outs), 64'(beats));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_left_pipe.md
Name: shift_left_pipe

Overview:
- Pipelined lane-granular left shifter. It is the transmit-side counterpart of the combinational lane right shifter.
- Shifts a 50-bit word left by shift×5 bits, in 5-bit lanes.
- Vacated low lanes are loaded with a 5-bit fill pattern.
- Two register stages with valid/ready handshakes on both sides, so it drops into the streaming datapath without timing issues.

Parameters:
- LANE_W, 5, bits per lane.
- LANES, 10, lanes per word. Data width is LANE_W*LANES = 50.
- SHIFT_W, 3, width of the shift-amount field.
- MAX_SHIFT, 4, largest legal shift in lanes. Larger values are out of range.

Ports:
- clk  in  1  single clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the input beat this cycle.
- in  in  50  data word.
- shift  in  3  left shift amount, in lanes.
- fill  in  5  pattern loaded into every vacated low lane.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the output beat.
- out  out  50  shifted word.
- out_range_ok  out  1  1 if the beat's shift was ≤ MAX_SHIFT.

Behaviour:
- Reset (asynchronous, active-high):
  - s1_valid=0, s2_valid=0, out_valid=0, out=0, out_range_ok=0.
  - in_ready is 1 during and after reset, because the pipeline is empty.
- Transfers:
  - Input transfer happens when in_valid & in_ready.
  - Output transfer happens when out_valid & out_ready.
- Function, for shift s ≤ 4: out lane k = in lane (k−s) for k ≥ s; out lane k = fill for k < s. Lane k is bits [5k+4:5k].
- Out-of-range shift (s = 5, 6, 7): out = fill replicated into all 10 lanes, out_range_ok=0. This is the complement of the right shifter's out-of-range flag, carried with the beat.
- Stage 1 (captured on input transfer):
  - Applies shift[0] (1 lane) and shift[1] (2 lanes), inserting fill.
  - Registers the partial word, fill, shift[2] and range_ok = (shift ≤ MAX_SHIFT).
- Stage 2 (captured when stage 1 advances):
  - Applies shift[2] (4 lanes), inserting fill.
  - Forces all-fill if range_ok=0.
  - Drives out, out_range_ok and out_valid directly from registers. No combinational path from in to out.
- Latency is 2 cycles from input transfer to out_valid with no stall. Throughput is 1 beat per cycle.
- Ready chain:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv
  - in_ready depends combinationally on out_ready only, never on in_valid.
- Stall: while out_valid=1 and out_ready=0, out and out_range_ok hold stable. At most 2 beats are buffered, then in_ready=0.
- Ordering: beats leave in arrival order. No loss or duplication under any valid/ready pattern.
- Simultaneous events: a stage can load and unload in the same cycle. A full pipeline with out_ready=1 sustains in_ready=1.
- shift=0: out = in, out_range_ok=1.
- Reset mid-flight: in-flight beats are discarded and out_valid drops asynchronously. The next accepted beat produces output 2 cycles after its transfer.
- Inputs are sampled only on transfer. Changes on in, shift or fill without in_valid have no effect.

Decomposition:
- Shared package shift_pkg holds LANE_W, LANES, DATA_W=50, SHIFT_W, MAX_SHIFT, a lane-array typedef, and a range-check function. The package is shared with the right shifter.
- One natural sub-module, shift_left_stage: a combinational lane shifter by a constant lane count, with a select and fill. It is instantiated for 1, 2 and 4 lanes.
- Pipeline registers and handshake logic stay in the top.

Test Plan:
- Basic shift: in=50'h1F, shift=3, fill=5'h0A, out_ready=1 → two cycles later out=50'hFA94A, out_range_ok=1, out_valid pulses for 1 cycle.
- Max shift: in=50'h3FFFFFFFFFFFF, shift=4, fill=0 → out=50'h3FFFFFFF00000, out_range_ok=1.
- Out of range: shift=6, fill=5'h1F, any in → out=50'h3FFFFFFFFFFFF, out_range_ok=0. Also shift=0 → out=in.
- Backpressure: send 3 beats with out_ready=0 → in_ready=0 after 2 accepted, out holds beat 1. Raise out_ready → beats 1, 2, 3 appear in order, 1 per cycle.
- Streaming: random in/shift/fill with random valid/ready for 10k beats → every output matches the scoreboard model, no drops or duplicates, and out is stable while stalled.
- Reset: assert rst with 2 beats in flight → out_valid=0 immediately, in_ready=1. After release, 1 beat with shift=1 → out appears 2 cycles after its transfer.
